// File: rtl/fp32_pkg.sv
// Shared constants and FSM state type for the sequential FP32 multiplier.
package fp32_pkg;
    localparam int          BIAS    = 127;
    localparam int          EXP_W   = 8;
    localparam int          MAN_W   = 23;
    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  EXP_INF = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        NORM  = 2'd2,
        ROUND = 2'd3
    } state_t;
endpackage

// File: rtl/fp32_round.sv
// Combinational round + renormalise + exponent range check for a normalised 24-bit significand.
// Round-to-nearest-even when FP32MULT_RNE_EN is defined, truncation otherwise.
module fp32_round
    import fp32_pkg::*;
(
    input  logic              sign,
    input  logic signed [9:0] exp_in,
    input  logic [23:0]       mant,
    input  logic              guard,
    input  logic              sticky,
    output logic [31:0]       res,
    output logic              ovf,
    output logic              unf
);
    logic              inc;
    logic [24:0]       sum;
    logic [MAN_W-1:0]  frac_r;
    logic signed [9:0] exp_r;
    logic              unused_gs;

    assign unused_gs = guard ^ sticky;

    always_comb begin
`ifdef FP32MULT_RNE_EN
        inc = guard & (sticky | mant[0]);
`else
        inc = 1'b0;
`endif
        sum = {1'b0, mant} + 25'(inc);
        // Carry-out means the significand rolled over to 2.0: fraction is zero, bump exponent.
        if (sum[24]) begin
            frac_r = sum[23:1];
            exp_r  = exp_in + 10'sd1;
        end else begin
            frac_r = sum[22:0];
            exp_r  = exp_in;
        end
        res = {sign, exp_r[EXP_W-1:0], frac_r};
        ovf = 1'b0;
        unf = 1'b0;
        if (exp_r >= 10'sd255) begin
            res = {sign, EXP_INF, 23'd0};
            ovf = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            res = {sign, 31'd0};
            unf = 1'b1;
        end
    end
endmodule

// File: rtl/fp32_mult_seq.sv
// Sequential IEEE-754 single multiplier: shift-add over 24/RADIX_BITS cycles, then NORM and ROUND.
// Optional macro FP32MULT_RNE_EN selects round-to-nearest-even (default: truncate).
module fp32_mult_seq
    import fp32_pkg::*;
#(
    parameter int RADIX_BITS = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        ovf,
    output logic        unf,
    output logic        nan
);
    localparam int N     = 24 / RADIX_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [47:0]       ma_q, ma_d;
    logic [23:0]       mb_q, mb_d;
    logic [47:0]       acc_q, acc_d;
    logic signed [9:0] exp_q, exp_d;
    logic              sign_q, sign_d;
    logic              sp_nan_q, sp_nan_d;
    logic              sp_inf_q, sp_inf_d;
    logic              sp_zero_q, sp_zero_d;
    logic [23:0]       mant_q, mant_d;
    logic              guard_q, guard_d;
    logic              sticky_q, sticky_d;
    logic [31:0]       result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              nan_q, nan_d;
    logic              done_q, done_d;

    logic              a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, in_nan;
    logic [31:0]       rnd_res;
    logic              rnd_ovf, rnd_unf;

    assign a_zero = (a[30:23] == 8'd0);
    assign b_zero = (b[30:23] == 8'd0);
    assign a_inf  = (a[30:23] == EXP_INF) && (a[22:0] == 23'd0);
    assign b_inf  = (b[30:23] == EXP_INF) && (b[22:0] == 23'd0);
    assign a_nan  = (a[30:23] == EXP_INF) && (a[22:0] != 23'd0);
    assign b_nan  = (b[30:23] == EXP_INF) && (b[22:0] != 23'd0);
    assign in_nan = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);

    fp32_round u_round (
        .sign   (sign_q),
        .exp_in (exp_q),
        .mant   (mant_q),
        .guard  (guard_q),
        .sticky (sticky_q),
        .res    (rnd_res),
        .ovf    (rnd_ovf),
        .unf    (rnd_unf)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ma_d      = ma_q;
        mb_d      = mb_q;
        acc_d     = acc_q;
        exp_d     = exp_q;
        sign_d    = sign_q;
        sp_nan_d  = sp_nan_q;
        sp_inf_d  = sp_inf_q;
        sp_zero_d = sp_zero_q;
        mant_d    = mant_q;
        guard_d   = guard_q;
        sticky_d  = sticky_q;
        result_d  = result_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        nan_d     = nan_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ma_d      = {25'd1, a[22:0]};
                    mb_d      = {1'b1, b[22:0]};
                    acc_d     = 48'd0;
                    cnt_d     = '0;
                    sign_d    = a[31] ^ b[31];
                    exp_d     = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]})
                                - 10'(BIAS);
                    sp_nan_d  = in_nan;
                    sp_inf_d  = (a_inf | b_inf) & ~in_nan;
                    sp_zero_d = (a_zero | b_zero) & ~in_nan;
                    state_d   = MULT;
                end
            end
            MULT: begin
                // Retire the low RADIX_BITS multiplier bits against the pre-shifted multiplicand.
                acc_d = acc_q + ma_q * 48'(mb_q[RADIX_BITS-1:0]);
                ma_d  = ma_q << RADIX_BITS;
                mb_d  = mb_q >> RADIX_BITS;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(N - 1)) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (acc_q[47]) begin
                    mant_d   = acc_q[47:24];
                    guard_d  = acc_q[23];
                    sticky_d = |acc_q[22:0];
                    exp_d    = exp_q + 10'sd1;
                end else begin
                    mant_d   = acc_q[46:23];
                    guard_d  = acc_q[22];
                    sticky_d = |acc_q[21:0];
                end
                state_d = ROUND;
            end
            ROUND: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
                nan_d = 1'b0;
                if (sp_nan_q) begin
                    result_d = QNAN;
                    nan_d    = 1'b1;
                end else if (sp_zero_q) begin
                    result_d = {sign_q, 31'd0};
                end else if (sp_inf_q) begin
                    result_d = {sign_q, EXP_INF, 23'd0};
                end else begin
                    result_d = rnd_res;
                    ovf_d    = rnd_ovf;
                    unf_d    = rnd_unf;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ma_q      <= 48'd0;
            mb_q      <= 24'd0;
            acc_q     <= 48'd0;
            exp_q     <= 10'sd0;
            sign_q    <= 1'b0;
            sp_nan_q  <= 1'b0;
            sp_inf_q  <= 1'b0;
            sp_zero_q <= 1'b0;
            mant_q    <= 24'd0;
            guard_q   <= 1'b0;
            sticky_q  <= 1'b0;
            result_q  <= 32'd0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            nan_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            acc_q     <= acc_d;
            exp_q     <= exp_d;
            sign_q    <= sign_d;
            sp_nan_q  <= sp_nan_d;
            sp_inf_q  <= sp_inf_d;
            sp_zero_q <= sp_zero_d;
            mant_q    <= mant_d;
            guard_q   <= guard_d;
            sticky_q  <= sticky_d;
            result_q  <= result_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            nan_q     <= nan_d;
            done_q    <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign ovf    = ovf_q;
    assign unf    = unf_q;
    assign nan    = nan_q;
endmodule
